// File: rtl/game_pkg.sv
// Shared game-state encodings for the controller, game logic and renderer.
package game_pkg;

    localparam logic [1:0] StTitle = 2'b00;
    localparam logic [1:0] StMain  = 2'b01;
    localparam logic [1:0] StOver  = 2'b10;
    localparam logic [1:0] StWin   = 2'b11;

    // OVER and WIN share the upper bit, so both end screens decode from it alone.
    function automatic logic is_end_state(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one pushbutton.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // A sample that agrees with the debounced level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/game_fsm.sv
// Top-level game flow controller: button conditioning, title/main/end-screen FSM,
// end-screen hold timer and blink strobe.
module game_fsm
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned END_HOLD_CYCLES = 150_000_000,
    parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_fire_raw,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       game_over,
    input  logic       game_win,
    output logic       fire,
    output logic       left,
    output logic       right,
    output logic [1:0] game_state,
    output logic       round_reset,
    output logic       blink
);

    localparam int unsigned HoldW  = $clog2(END_HOLD_CYCLES + 1);
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic deb_fire, deb_left, deb_right;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fire (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn_fire_raw),
        .level_o(deb_fire)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn_left_raw),
        .level_o(deb_left)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn_right_raw),
        .level_o(deb_right)
    );

    logic [1:0]        state_q, state_d;
    logic              fire_prev_q, fire_rise_q, fire_rise_d;
    logic              armed_q, armed_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              hold_sat;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              fire_q, fire_d, left_q, left_d, right_q, right_d;
    logic              round_reset_q, round_reset_d;
    logic              main_next;

    always_comb begin
        fire_rise_d = deb_fire & ~fire_prev_q;
        hold_sat    = (hold_q == HoldW'(END_HOLD_CYCLES));

        state_d = state_q;
        case (state_q)
            StTitle: if (fire_rise_q) state_d = StMain;
            StMain: begin
                if (game_over)     state_d = StOver;
                else if (game_win) state_d = StWin;
            end
            default: if (fire_rise_q && hold_sat) state_d = StTitle;
        endcase

        // The pulse coincides with fire_rise; the state moves to MAIN one cycle later.
        round_reset_d = (state_q == StTitle) && fire_rise_d;

        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = '0;
        end else if (is_end_state(state_q) && !hold_sat) begin
            hold_d = hold_q + HoldW'(1);
        end

        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if ((state_d != state_q) || !is_end_state(state_q)) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end

        // A fire held across the start of a round must be released before it counts.
        armed_d = armed_q;
        if (state_q != StMain) begin
            armed_d = 1'b0;
        end else if (!deb_fire) begin
            armed_d = 1'b1;
        end

        main_next = (state_d == StMain);
        fire_d    = main_next && armed_d && deb_fire;
        left_d    = main_next && deb_left;
        right_d   = main_next && deb_right;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StTitle;
            fire_prev_q   <= 1'b0;
            fire_rise_q   <= 1'b0;
            armed_q       <= 1'b0;
            hold_q        <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            fire_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            round_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fire_prev_q   <= deb_fire;
            fire_rise_q   <= fire_rise_d;
            armed_q       <= armed_d;
            hold_q        <= hold_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            fire_q        <= fire_d;
            left_q        <= left_d;
            right_q       <= right_d;
            round_reset_q <= round_reset_d;
        end
    end

    assign fire        = fire_q;
    assign left        = left_q;
    assign right       = right_q;
    assign game_state  = state_q;
    assign round_reset = round_reset_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with short debounce, hold and blink periods.
module tb_game_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_fire_raw, btn_left_raw, btn_right_raw;
    logic       game_over, game_win;
    logic       fire, left, right, round_reset, blink;
    logic [1:0] game_state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    game_fsm #(
        .DEBOUNCE_CYCLES(4),
        .END_HOLD_CYCLES(16),
        .BLINK_CYCLES   (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_fire_raw (btn_fire_raw),
        .btn_left_raw (btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .game_over    (game_over),
        .game_win     (game_win),
        .fire         (fire),
        .left         (left),
        .right        (right),
        .game_state   (game_state),
        .round_reset  (round_reset),
        .blink        (blink)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input int step, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, step, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input int step, input logic [1:0] got,
                               input logic [1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, step, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_state(tag, 0, game_state, 2'b00);
        check_bit(tag, 0, fire, 1'b0);
        check_bit(tag, 0, left, 1'b0);
        check_bit(tag, 0, right, 1'b0);
        check_bit(tag, 0, round_reset, 1'b0);
        check_bit(tag, 0, blink, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        btn_fire_raw  = 1'b0;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        game_over     = 1'b0;
        game_win      = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Short 3-cycle fire pulse is rejected.
        for (int n = 1; n <= 12; n++) begin
            btn_fire_raw = (n <= 3);
            tick();
            check_bit("short_pulse_rr", n, round_reset, 1'b0);
            check_state("short_pulse_state", n, game_state, 2'b00);
        end

        // 10-cycle press: round_reset at step 7, MAIN at step 8, fire held so stays 0.
        for (int n = 1; n <= 20; n++) begin
            btn_fire_raw = (n <= 10);
            tick();
            check_bit("start_rr", n, round_reset, n == 7);
            check_state("start_state", n, game_state, (n >= 8) ? 2'b01 : 2'b00);
            check_bit("start_fire_unarmed", n, fire, 1'b0);
        end

        // Re-press in MAIN: fire follows debounced level, one register behind.
        for (int n = 1; n <= 16; n++) begin
            btn_fire_raw = (n <= 7);
            tick();
            check_bit("main_fire", n, fire, (n >= 7) && (n <= 13));
        end

        // Both directions pressed together pass through.
        for (int n = 1; n <= 8; n++) begin
            btn_left_raw  = 1'b1;
            btn_right_raw = 1'b1;
            tick();
            check_bit("main_left", n, left, n >= 7);
            check_bit("main_right", n, right, n >= 7);
        end

        // Over and win together: OVER wins, controls drop immediately.
        game_over = 1'b1;
        game_win  = 1'b1;
        tick();
        game_over     = 1'b0;
        game_win      = 1'b0;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        check_state("over_entry", 0, game_state, 2'b10);
        check_bit("over_left", 0, left, 1'b0);
        check_bit("over_right", 0, right, 1'b0);
        check_bit("over_fire", 0, fire, 1'b0);

        for (int n = 1; n <= 10; n++) begin
            tick();
            check_state("over_state", n, game_state, 2'b10);
            check_bit("over_blink", n, blink, n >= 8);
            check_bit("over_left_hold", n, left, 1'b0);
        end

        // One-cycle reset with the hold counter at 10.
        reset_n = 1'b0;
        tick();
        check_all_zero("mid_hold_reset");
        reset_n = 1'b1;

        game_over = 1'b1;
        tick();
        check_state("title_ignores_over", 0, game_state, 2'b00);
        game_over = 1'b0;

        // Fresh press needs the full debounce again.
        for (int n = 1; n <= 16; n++) begin
            btn_fire_raw = (n <= 8);
            tick();
            check_bit("restart_rr", n, round_reset, n == 7);
            check_state("restart_state", n, game_state, (n >= 8) ? 2'b01 : 2'b00);
        end

        game_win = 1'b1;
        tick();
        game_win = 1'b0;
        check_state("win_entry", 0, game_state, 2'b11);

        // Early press ignored, late press returns to TITLE without round_reset.
        for (int n = 1; n <= 29; n++) begin
            btn_fire_raw = ((n >= 6) && (n <= 12)) || (n >= 21);
            tick();
            check_state("win_state", n, game_state, (n >= 28) ? 2'b00 : 2'b11);
            check_bit("win_blink", n, blink, (n < 28) && (((n / 8) % 2) == 1));
            check_bit("win_rr", n, round_reset, 1'b0);
            check_bit("win_fire", n, fire, 1'b0);
        end

        btn_fire_raw = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
